conv3x3_stream_engine: RTL and testbench

Parametrised successor to the fixed 3x3 pixel processor: streaming engine with ready/valid on both sides, runtime-selectable mode (bypass, invert, 3x3 convolution), programmable right-shift normalisation and saturating output. Sits between the async FIFO read side and downstream consumers in the system clock domain. Internal line buffers build the 3x3 window. Mode, shift and weights are shadowed per frame.

---
 rtl/conv3x3_stream_engine.sv | 181 ++++++++++++++++++
 tb/tb_conv3x3_stream_engine.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 pixel engine: bypass, invert or valid-region convolution with
// shift/saturate; mode, shift and weights are latched per frame at pixel (0,0).
module conv3x3_stream_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic                  out_last,
  input  logic                  reg_write_en,
  input  logic [4:0]            reg_addr,
  input  logic [7:0]            reg_wdata,
  output logic [7:0]            reg_rdata
);
  localparam int CB = $clog2(IMG_WIDTH);
  localparam int RB = $clog2(IMG_HEIGHT);
  localparam int PW = DATA_WIDTH + 1 + COEF_WIDTH;
  localparam int AW = DATA_WIDTH + COEF_WIDTH + 4;
  localparam logic signed [AW-1:0] PIX_MAX = AW'((1 << DATA_WIDTH) - 1);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_CONV   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  mode_e                        ctrl_q, act_mode, cur_mode;
  logic [3:0]                   shift_q, act_shift, cur_shift;
  logic [7:0]                   frame_cnt;
  logic signed [COEF_WIDTH-1:0] w_q   [9];
  logic signed [COEF_WIDTH-1:0] act_w [9];

  logic [CB-1:0]         col;
  logic [RB-1:0]         row;
  logic                  started, stall, accept, first, col_end, row_end;
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win [9];

  logic                  s1_valid, s1_conv, s1_last;
  logic [DATA_WIDTH-1:0] s1_pix;
  logic [3:0]            s1_shift;
  logic                  s2_valid, s2_conv, s2_last;
  logic [DATA_WIDTH-1:0] s2_pix;
  logic [3:0]            s2_shift;
  logic signed [PW-1:0]  prod [9];
  logic signed [AW-1:0]  acc, shifted;
  logic [DATA_WIDTH-1:0] result;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = started && !stall;
  assign accept    = in_valid && in_ready;
  assign first     = (row == '0) && (col == '0);
  assign col_end   = col == CB'(IMG_WIDTH - 1);
  assign row_end   = row == RB'(IMG_HEIGHT - 1);
  // Pixel (0,0) must already see the configuration it is shadowing.
  assign cur_mode  = first ? ctrl_q : act_mode;
  assign cur_shift = first ? shift_q : act_shift;

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      5'h00:   reg_rdata = 8'(ctrl_q);
      5'h01:   reg_rdata = 8'(shift_q);
      5'h02:   reg_rdata = frame_cnt;
      default: begin
        for (int unsigned k = 0; k < 9; k++)
          if (reg_addr == 5'(k + 4)) reg_rdata = 8'(w_q[k]);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      started   <= 1'b0;
      ctrl_q    <= MODE_BYPASS;
      shift_q   <= '0;
      act_mode  <= MODE_BYPASS;
      act_shift <= '0;
      for (int unsigned k = 0; k < 9; k++) begin
        w_q[k]   <= '0;
        act_w[k] <= '0;
      end
    end else begin
      started <= 1'b1;
      if (reg_write_en) begin
        if (reg_addr == 5'h00) ctrl_q <= mode_e'(reg_wdata[1:0]);
        if (reg_addr == 5'h01) shift_q <= reg_wdata[3:0];
        for (int unsigned k = 0; k < 9; k++)
          if (reg_addr == 5'(k + 4)) w_q[k] <= COEF_WIDTH'($signed(reg_wdata));
      end
      if (accept && first) begin
        act_mode  <= ctrl_q;
        act_shift <= shift_q;
        for (int unsigned k = 0; k < 9; k++) act_w[k] <= w_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col       <= '0;
      row       <= '0;
      frame_cnt <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        if (row_end) begin
          row       <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers hold rows r-1 (lb0) and r-2 (lb1); the window doubles as the S1 register.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= in_data;
      lb1[col] <= lb0[col];
      win[0] <= win[1]; win[1] <= win[2]; win[2] <= lb1[col];
      win[3] <= win[4]; win[4] <= win[5]; win[5] <= lb0[col];
      win[6] <= win[7]; win[7] <= win[8]; win[8] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0; s1_conv <= 1'b0; s1_last <= 1'b0; s1_pix <= '0; s1_shift <= '0;
      s2_valid <= 1'b0; s2_conv <= 1'b0; s2_last <= 1'b0; s2_pix <= '0; s2_shift <= '0;
      for (int unsigned k = 0; k < 9; k++) prod[k] <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept && (cur_mode != MODE_CONV ||
                             (row >= RB'(2) && col >= CB'(2)));
      if (accept) begin
        s1_conv  <= cur_mode == MODE_CONV;
        s1_pix   <= (cur_mode == MODE_INVERT) ? ~in_data : in_data;
        s1_last  <= row_end && col_end;
        s1_shift <= cur_shift;
      end
      s2_valid <= s1_valid;
      s2_conv  <= s1_conv;
      s2_last  <= s1_last;
      s2_pix   <= s1_pix;
      s2_shift <= s1_shift;
      for (int unsigned k = 0; k < 9; k++)
        prod[k] <= PW'($signed({1'b0, win[k]})) * PW'(act_w[k]);
      out_valid <= s2_valid;
      out_last  <= s2_valid && s2_last;
      if (s2_valid) out_pixel <= result;
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < 9; k++) acc = acc + AW'(prod[k]);
    shifted = acc >>> s2_shift;
    result  = s2_pix;
    if (s2_conv) begin
      if (shifted[AW-1])         result = '0;
      else if (shifted > PIX_MAX) result = '1;
      else                        result = shifted[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Self-checking bench for conv3x3_stream_engine against a window-centred frame model.
module tb_conv3x3_stream_engine;
  localparam int W = 32;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid, out_ready = 1'b1, out_last;
  logic [7:0] out_pixel;
  logic       reg_write_en = 1'b0;
  logic [4:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0, reg_rdata;

  always #5 clk = ~clk;

  conv3x3_stream_engine #(.DATA_WIDTH(8), .COEF_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last),
    .reg_write_en(reg_write_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  int checks = 0;
  int passes = 0;
  int img [H][W];
  int kw [9];
  logic [7:0] exp_pix[$];
  logic       exp_last[$];
  logic [7:0] got_pix[$];
  logic       got_last[$];

  always @(negedge clk)
    if (rstn && out_valid && out_ready) begin
      got_pix.push_back(out_pixel);
      got_last.push_back(out_last);
    end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference: one output per centre (i,j) in raster order; weight k sits at (i-1+k/3, j-1+k%3).
  function automatic void build_expected(input int mode, input int sh);
    int acc;
    exp_pix.delete();
    exp_last.delete();
    if (mode == 2) begin
      for (int i = 1; i < H - 1; i++)
        for (int j = 1; j < W - 1; j++) begin
          acc = 0;
          for (int k = 0; k < 9; k++) acc += kw[k] * img[i - 1 + k / 3][j - 1 + k % 3];
          acc = acc >>> sh;
          if (acc < 0) acc = 0;
          else if (acc > 255) acc = 255;
          exp_pix.push_back(8'(acc));
          exp_last.push_back(i == H - 2 && j == W - 2);
        end
    end else begin
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++) begin
          exp_pix.push_back(8'((mode == 1) ? 255 - img[i][j] : img[i][j]));
          exp_last.push_back(i == H - 1 && j == W - 1);
        end
    end
  endfunction

  task automatic push(input int d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL push_timeout in_ready=%0b after %0d cycles, required 1", in_ready, guard);
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) push(img[i][j]);
    in_valid = 1'b0;
  endtask

  task automatic write_reg(input int a, input int d);
    reg_write_en = 1'b1;
    reg_addr     = 5'(a);
    reg_wdata    = 8'(d);
    @(posedge clk);
    #1;
    reg_write_en = 1'b0;
  endtask

  task automatic set_kernel(input int k [9], input int sh);
    for (int i = 0; i < 9; i++) begin
      kw[i] = k[i];
      write_reg(4 + i, k[i] & 255);
    end
    write_reg(1, sh);
  endtask

  task automatic wait_outputs(input int n);
    int guard = 0;
    while (got_pix.size() < n && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    got_pix.delete();
    got_last.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passes++;
    checks++; if (out_pixel !== 8'h00) $display("FAIL reset_out_pixel got %0h want 00", out_pixel); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %0b want 0", out_last); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", in_ready); else passes++;
    reg_addr = 5'h02; #1;
    checks++; if (reg_rdata !== 8'h00) $display("FAIL reset_frame_cnt got %0h want 00", reg_rdata); else passes++;
    reg_addr = 5'h00; #1;
    checks++; if (reg_rdata !== 8'h00) $display("FAIL reset_ctrl got %0h want 00", reg_rdata); else passes++;
    reg_addr = 5'h08; #1;
    checks++; if (reg_rdata !== 8'h00) $display("FAIL reset_w4 got %0h want 00", reg_rdata); else passes++;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %0b want 1", in_ready); else passes++;
  endtask

  task automatic test_registers();
    write_reg(5'h04, 8'h81);
    checks++; if (reg_rdata !== 8'h81) $display("FAIL reg_w0_readback got %0h want 81", reg_rdata); else passes++;
    write_reg(5'h01, 8'h1F);
    checks++; if (reg_rdata !== 8'h0F) $display("FAIL reg_shift_readback got %0h want 0f", reg_rdata); else passes++;
    write_reg(5'h02, 8'h55);
    checks++; if (reg_rdata !== 8'h00) $display("FAIL reg_frame_cnt_ro got %0h want 00", reg_rdata); else passes++;
    write_reg(5'h0D, 8'h12);
    checks++; if (reg_rdata !== 8'h00) $display("FAIL reg_unmapped got %0h want 00", reg_rdata); else passes++;
    write_reg(5'h04, 0);
    write_reg(5'h01, 0);
  endtask

  task automatic test_bypass_ramp();
    write_reg(0, 0);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = (i * W + j) & 255;
    build_expected(0, 0);
    got_pix.delete(); got_last.delete();
    send_frame();
    wait_outputs(256);
    checks++; if (got_pix.size() !== 256) $display("FAIL bypass_count got %0d want 256", got_pix.size()); else passes++;
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix[i] || got_last[i] !== exp_last[i])
        $display("FAIL bypass_px[%0d] got %0h/%0b want %0h/%0b", i, got_pix[i], got_last[i], exp_pix[i], exp_last[i]);
      else passes++;
    end
    reg_addr = 5'h02; #1;
    checks++; if (reg_rdata !== 8'h01) $display("FAIL bypass_frame_cnt got %0h want 01", reg_rdata); else passes++;
  endtask

  task automatic test_invert_latency();
    int lat;
    int vals [2] = '{8'h3C, 8'h00};
    int want [2] = '{8'hC3, 8'hFF};
    write_reg(0, 1);
    for (int n = 0; n < 2; n++) begin
      in_valid = 1'b1;
      in_data  = 8'(vals[n]);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++; if (lat !== 3) $display("FAIL invert_latency[%0d] got %0d want 3", n, lat); else passes++;
      checks++;
      if (out_pixel !== 8'(want[n])) $display("FAIL invert_px[%0d] got %0h want %0h", n, out_pixel, want[n]);
      else passes++;
    end
    do_reset();
  endtask

  task automatic test_conv_const();
    write_reg(0, 2);
    set_kernel('{0, -1, 0, -1, 4, -1, 0, -1, 0}, 0);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = 100;
    build_expected(2, 0);
    got_pix.delete(); got_last.delete();
    send_frame();
    wait_outputs(180);
    checks++; if (got_pix.size() !== 180) $display("FAIL conv_const_count got %0d want 180", got_pix.size()); else passes++;
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix[i] || got_last[i] !== exp_last[i])
        $display("FAIL conv_const_px[%0d] got %0h/%0b want %0h/%0b", i, got_pix[i], got_last[i], exp_pix[i], exp_last[i]);
      else passes++;
    end
  endtask

  task automatic test_conv_impulse();
    int ci [5] = '{3, 2, 4, 3, 3};
    int cj [5] = '{5, 5, 5, 4, 6};
    int idx;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = 0;
    img[3][5] = 255;
    got_pix.delete(); got_last.delete();
    send_frame();
    wait_outputs(180);
    for (int n = 0; n < 5; n++) begin
      idx = (ci[n] - 1) * (W - 2) + (cj[n] - 1);
      checks++;
      if (idx >= got_pix.size()) $display("FAIL impulse_missing(%0d,%0d) got %0d outputs", ci[n], cj[n], got_pix.size());
      else if (got_pix[idx] !== ((n == 0) ? 8'hFF : 8'h00))
        $display("FAIL impulse(%0d,%0d) got %0h want %0h", ci[n], cj[n], got_pix[idx], (n == 0) ? 8'hFF : 8'h00);
      else passes++;
    end
    set_kernel('{0, 0, 0, 0, 4, 0, 0, 0, 0}, 2);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = int'($urandom_range(0, 255));
    got_pix.delete(); got_last.delete();
    send_frame();
    wait_outputs(180);
    checks++; if (got_pix.size() !== 180) $display("FAIL identity_count got %0d want 180", got_pix.size()); else passes++;
    for (int i = 1; i < H - 1; i++)
      for (int j = 1; j < W - 1; j++) begin
        idx = (i - 1) * (W - 2) + (j - 1);
        if (idx < got_pix.size()) begin
          checks++;
          if (got_pix[idx] !== 8'(img[i][j])) $display("FAIL identity(%0d,%0d) got %0h want %0h", i, j, got_pix[idx], img[i][j]);
          else passes++;
        end
      end
  endtask

  task automatic test_backpressure();
    int k [9];
    int sh;
    for (int i = 0; i < 9; i++) k[i] = int'($urandom_range(0, 16)) - 8;
    sh = int'($urandom_range(0, 3));
    set_kernel(k, sh);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = int'($urandom_range(0, 255));
    build_expected(2, sh);
    got_pix.delete(); got_last.delete();
    fork
      send_frame();
      begin
        logic [7:0] held;
        logic       held_last;
        int         guard = 0;
        repeat (100) @(posedge clk);
        #1;
        out_ready = 1'b0;
        while (!out_valid && guard < 50) begin
          @(posedge clk);
          #1;
          guard++;
        end
        held = out_pixel;
        held_last = out_last;
        repeat (10) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_pixel !== held || out_last !== held_last)
            $display("FAIL stall_hold got v=%0b rdy=%0b px=%0h last=%0b want v=1 rdy=0 px=%0h last=%0b",
                     out_valid, in_ready, out_pixel, out_last, held, held_last);
          else passes++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (200) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(180);
    checks++; if (got_pix.size() !== 180) $display("FAIL bp_count got %0d want 180", got_pix.size()); else passes++;
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix[i] || got_last[i] !== exp_last[i])
        $display("FAIL bp_px[%0d] got %0h/%0b want %0h/%0b", i, got_pix[i], got_last[i], exp_pix[i], exp_last[i]);
      else passes++;
    end
  endtask

  task automatic test_midframe_ctrl();
    set_kernel('{0, -1, 0, -1, 4, -1, 0, -1, 0}, 0);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = int'($urandom_range(0, 255));
    build_expected(2, 0);
    got_pix.delete(); got_last.delete();
    fork
      send_frame();
      begin
        repeat (100) @(posedge clk);
        #1;
        write_reg(0, 1);
      end
    join
    wait_outputs(180);
    checks++; if (got_pix.size() !== 180) $display("FAIL midctrl_conv_count got %0d want 180", got_pix.size()); else passes++;
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix[i] || got_last[i] !== exp_last[i])
        $display("FAIL midctrl_conv_px[%0d] got %0h/%0b want %0h/%0b", i, got_pix[i], got_last[i], exp_pix[i], exp_last[i]);
      else passes++;
    end
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = int'($urandom_range(0, 255));
    build_expected(1, 0);
    got_pix.delete(); got_last.delete();
    send_frame();
    wait_outputs(256);
    checks++; if (got_pix.size() !== 256) $display("FAIL midctrl_inv_count got %0d want 256", got_pix.size()); else passes++;
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix[i] || got_last[i] !== exp_last[i])
        $display("FAIL midctrl_inv_px[%0d] got %0h/%0b want %0h/%0b", i, got_pix[i], got_last[i], exp_pix[i], exp_last[i]);
      else passes++;
    end
  endtask

  task automatic test_reset_midframe();
    for (int n = 0; n < 100; n++) push(int'($urandom_range(0, 255)));
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid got %0b want 0", out_valid); else passes++;
    reg_addr = 5'h02; #1;
    checks++; if (reg_rdata !== 8'h00) $display("FAIL midreset_frame_cnt got %0h want 00", reg_rdata); else passes++;
    do_reset();
    write_reg(0, 3);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = int'($urandom_range(0, 255));
    build_expected(0, 0);
    send_frame();
    wait_outputs(256);
    checks++; if (got_pix.size() !== 256) $display("FAIL postreset_count got %0d want 256", got_pix.size()); else passes++;
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix[i] || got_last[i] !== exp_last[i])
        $display("FAIL postreset_px[%0d] got %0h/%0b want %0h/%0b", i, got_pix[i], got_last[i], exp_pix[i], exp_last[i]);
      else passes++;
    end
    reg_addr = 5'h02; #1;
    checks++; if (reg_rdata !== 8'h01) $display("FAIL postreset_frame_cnt got %0h want 01", reg_rdata); else passes++;
  endtask

  initial begin
    test_reset();
    test_registers();
    test_bypass_ramp();
    test_invert_latency();
    test_conv_const();
    test_conv_impulse();
    test_backpressure();
    test_midframe_ctrl();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
